// File: rtl/rv523_scan_pkg.sv
// Shared definitions for the scannable register chain: controller state
// encoding and the shift-counter width helper.
package rv523_scan_pkg;

  // Controller states; 2'b11 is unused and decodes back to idle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } scan_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/scan_mux_bit.sv
// One register bit: AOI22 next-state mux (functional pair + scan pair)
// feeding a clock-enabled D flop. Hold is done by the enable, not the mux.
module scan_mux_bit (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  input  logic load_sel,
  input  logic shift_i,
  input  logic shift_sel,
  output logic q_o
);

  logic y_c;
  logic q_d;
  logic q_q;

  // AOI22 cell; idles at 1 when neither select is active.
  always_comb begin
    y_c = ~((d_i & load_sel) | (shift_i & shift_sel));
  end

  // Flop captures the inverted AOI output only when a select is active.
  always_comb begin
    q_d = q_q;
    if (load_sel | shift_sel) begin
      q_d = ~y_c;
    end
  end

  // Bit storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/scan_reg_chain.sv
// Scannable parallel-load register with a controller that shifts the whole
// register out LSB-first on request while filling it from SI.
module scan_reg_chain
  import rv523_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             START,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CW = cnt_width(WIDTH);

  scan_state_e      state_d;
  scan_state_e      state_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    cnt_q;
  logic             busy_d;
  logic             busy_q;
  logic             done_d;
  logic             done_q;
  logic             load_sel_c;
  logic             shift_sel_c;
  logic [WIDTH-1:0] q_c;
  logic [WIDTH-1:0] shift_src_c;

  // Next state, counter and mux selects; selects are mutually exclusive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_sel_c  = 1'b0;
    shift_sel_c = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SHIFT;
          cnt_d   = CW'(WIDTH);
        end else if (EN) begin
          load_sel_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        shift_sel_c = 1'b1;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // Controller registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Each bit shifts in from its upper neighbour; the MSB takes SI.
  always_comb begin
    shift_src_c = {SI, q_c[WIDTH-1:1]};
  end

  // Register bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    scan_mux_bit u_bit (
      .clk       (CLK),
      .rst       (RST),
      .d_i       (D[i]),
      .load_sel  (load_sel_c),
      .shift_i   (shift_src_c[i]),
      .shift_sel (shift_sel_c),
      .q_o       (q_c[i])
    );
  end

  assign Q    = q_c;
  assign SO   = q_c[0];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_scan_reg_chain.sv
// Directed bench for scan_reg_chain with a queue of expected values.
module tb_scan_reg_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       en;
  logic       start;
  logic       si;
  logic [7:0] q;
  logic       so;
  logic       busy;
  logic       done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb[$];
  logic [7:0]  mq;

  always #5 clk = ~clk;

  scan_reg_chain #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RST   (rst),
    .D     (d),
    .EN    (en),
    .START (start),
    .SI    (si),
    .Q     (q),
    .SO    (so),
    .BUSY  (busy),
    .DONE  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full shift from IDLE; START is driven by the caller's state of en/d.
  task automatic do_shift(input string tag, input logic [7:0] si_bits,
                          input logic en_in, input logic [7:0] d_in);
    logic [31:0] v;
    for (int k = 0; k < 8; k++) sb.push_back(32'(mq[k]));
    start = 1'b1;
    tick();
    start = 1'b0;
    en    = en_in;
    d     = d_in;
    for (int k = 0; k < 8; k++) begin
      si = si_bits[k];
      v  = sb.pop_front();
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_done_early"}, 32'(done), 32'd0);
      chk({tag, "_so"}, 32'(so), v);
      tick();
    end
    mq = si_bits;
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_done"}, 32'(done), 32'd1);
    chk({tag, "_end_q"}, 32'(q), 32'(mq));
    tick();
    en = 1'b0;
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_q"}, 32'(q), 32'(mq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  exp1;
    logic [7:0]  exp2;
    logic        bb;
    logic        dn;

    // Reset with load requested.
    rst = 1'b1; en = 1'b1; d = 8'hFF; start = 1'b0; si = 1'b0;
    tick();
    tick();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_so", 32'(so), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Parallel load then hold.
    en = 1'b1; d = 8'hA5;
    tick();
    en = 1'b0; d = 8'h3C;
    mq = 8'hA5;
    chk("load_q", 32'(q), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_q", 32'(q), 32'(mq));
    end

    // Scan shift of A5 with SI = 1,1,0,0,0,0,1,1.
    do_shift("shift", 8'hC3, 1'b0, 8'h3C);
    chk("shift_final", 32'(q), 32'hC3);

    // START beats EN; EN ignored during the shift and DONE.
    en = 1'b1; d = 8'h00;
    do_shift("prio", 8'h69, 1'b1, 8'h55);

    // Reset at the 4th shift edge.
    en = 1'b1; d = 8'hFF;
    tick();
    en = 1'b0;
    mq = 8'hFF;
    chk("mid_load", 32'(q), 32'hFF);
    start = 1'b1;
    tick();
    start = 1'b0;
    si = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = 8'h00;
    chk("mid_q", 32'(q), 32'h00);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_done", 32'(done), 32'd0);
      chk("mid_idle_busy", 32'(busy), 32'd0);
    end
    do_shift("restart", 8'h5A, 1'b0, 8'h00);

    // START held high for 20 edges: two sequences with one IDLE between.
    exp1 = 8'h00;
    exp2 = 8'h00;
    for (int i = 0; i < 20; i++) begin
      bb = (i < 8) || (i >= 10 && i < 18);
      dn = (i == 8) || (i == 18);
      sb.push_back({30'd0, bb, dn});
      start = 1'b1;
      si = ((i % 3) == 0);
      if (i >= 1 && i <= 8) exp1[i-1] = si;
      if (i >= 11 && i <= 18) exp2[i-11] = si;
      tick();
      v = sb.pop_front();
      chk("b2b_busy", 32'(busy), 32'(v[1]));
      chk("b2b_done", 32'(done), 32'(v[0]));
      if (i == 8) chk("b2b_q1", 32'(q), 32'(exp1));
    end
    start = 1'b0;
    tick();
    chk("b2b_end_busy", 32'(busy), 32'd0);
    chk("b2b_end_done", 32'(done), 32'd0);
    chk("b2b_q2", 32'(q), 32'(exp2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
